// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: walks a one-hot digit enable,
// steers the active BCD nibble to a shared decoder, commits loads on frame edges.

module sevseg_digit_vis #(
    parameter bit LSD = 1'b0
) (
    input  logic [3:0] nib,
    input  logic       upper_zero,
    input  logic       lzb,
    output logic       vis,
    output logic       zero_out
);
    // zero_out: this nibble and every more-significant nibble are zero
    assign zero_out = upper_zero & (nib == 4'd0);
    assign vis      = (nib <= 4'd9) & ~(lzb & !LSD & zero_out);
endmodule

module sevseg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int BLANK  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  lzb,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     an,
    output logic [2:0]            dig_idx,
    output logic                  frame,
    output logic                  pending
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {S_BLANK, S_ON} state_t;
    localparam state_t S_RST = (BLANK == 0) ? S_ON : S_BLANK;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [2:0]              idx;
    logic [4*DIGITS-1:0]     disp, shadow;
    logic                    started;

    logic [DIGITS-1:0][3:0]  nibs;
    logic [DIGITS:0]         zchain;
    logic [DIGITS-1:0]       vis;
    logic                    last_cnt, end_blank, last_dig, frame_edge;
    logic [3:0]              cur_nib;
    logic [DIGITS-1:0]       an_nxt;

    assign nibs           = disp;
    assign zchain[DIGITS] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_dig
            sevseg_digit_vis #(.LSD(k == 0)) u_vis (
                .nib        (nibs[k]),
                .upper_zero (zchain[k+1]),
                .lzb        (lzb),
                .vis        (vis[k]),
                .zero_out   (zchain[k])
            );
        end
    endgenerate

    // cnt/idx name the slot position that the next edge puts on the outputs
    assign last_cnt   = (cnt == CW'(DIV - 1));
    assign end_blank  = (BLANK > 0) && (cnt == CW'(BLANK - 1));
    assign last_dig   = (idx == 3'(DIGITS - 1));
    assign frame_edge = last_cnt && last_dig;

    always_comb begin
        state_nxt = state;
        case (state)
            S_BLANK: if (end_blank) state_nxt = S_ON;
            S_ON:    if (last_cnt)  state_nxt = (BLANK > 0) ? S_BLANK : S_ON;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        cur_nib = 4'd0;
        an_nxt  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_nib   = nibs[i];
                an_nxt[i] = (state == S_ON) & vis[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RST;
            cnt     <= '0;
            idx     <= 3'd0;
            disp    <= '0;
            shadow  <= '0;
            started <= 1'b0;
            pending <= 1'b0;
            an      <= '0;
            bcd     <= 4'd0;
            dig_idx <= 3'd0;
            frame   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= last_cnt ? '0 : cnt + CW'(1);
            if (last_cnt)
                idx <= last_dig ? 3'd0 : idx + 3'd1;
            started <= 1'b1;

            if (load)
                shadow <= din;
            // a load on the commit edge bypasses the shadow buffer
            if (frame_edge) begin
                if (load)
                    disp <= din;
                else if (pending)
                    disp <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            an      <= an_nxt;
            bcd     <= (state == S_ON) ? cur_nib : 4'd0;
            dig_idx <= idx;
            frame   <= started && (cnt == '0) && (idx == 3'd0);
        end
    end
endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Scoreboard bench for sevseg_scan_ctrl: stimulus queues per-slot expectations,
// a monitor pops and compares them as each slot's enable becomes valid.

module tb_sevseg_scan_ctrl;
    localparam int D  = 4;
    localparam int DV = 16;
    localparam int BL = 4;
    localparam int FP = D * DV;

    logic          clk = 1'b0;
    logic          rst, load, lzb;
    logic [15:0]   din;
    logic [3:0]    bcd;
    logic [D-1:0]  an;
    logic [2:0]    dig_idx;
    logic          frame, pending;

    int checks = 0;
    int errors = 0;
    int tcnt;

    typedef struct {
        int         idx;
        logic [3:0] an;
        logic [3:0] bcd;
    } exp_t;
    exp_t q[$];
    exp_t cur;
    logic have_cur = 1'b0;

    sevseg_scan_ctrl #(.DIGITS(D), .DIV(DV), .BLANK(BL)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .din     (din),
        .lzb     (lzb),
        .bcd     (bcd),
        .an      (an),
        .dig_idx (dig_idx),
        .frame   (frame),
        .pending (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) tcnt <= -1;
        else     tcnt <= tcnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (t=%0d): got %0h expected %0h", name, tcnt, act, exp);
        end
    endtask

    task automatic push_frame(input logic [3:0] vmask, input logic [15:0] v, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.idx = k;
            e.an  = vmask[k] ? 4'(1 << k) : 4'd0;
            e.bcd = v[4*k +: 4];
            q.push_back(e);
        end
    endtask

    task automatic at_neg(input int t);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (tcnt != t && g < 2000);
        if (tcnt != t) begin
            checks++;
            errors++;
            $display("FAIL at_neg timeout: tcnt=%0d wanted %0d", tcnt, t);
        end
    endtask

    task automatic do_load(input int t, input logic [15:0] v);
        at_neg(t - 1);
        din  = v;
        load = 1'b1;
        at_neg(t);
        load = 1'b0;
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst && tcnt >= 0) begin
            if (tcnt % DV == 0)
                check("frame", 32'(frame), 32'((tcnt % FP == 0) && (tcnt > 0)));
            if (tcnt % DV == BL - 1)
                check("blank_an", 32'(an), 32'd0);
            if (tcnt % DV == BL) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    have_cur = 1'b0;
                    $display("FAIL scoreboard empty at t=%0d: an=%b bcd=%h", tcnt, an, bcd);
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    check("slot_idx", 32'(dig_idx), 32'(cur.idx));
                    check("slot_an",  32'(an),      32'(cur.an));
                    check("slot_bcd", 32'(bcd),     32'(cur.bcd));
                end
            end
            if (tcnt % DV == DV - 1 && have_cur) begin
                check("hold_an",  32'(an),  32'(cur.an));
                check("hold_bcd", 32'(bcd), 32'(cur.bcd));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        din  = 16'h0;
        lzb  = 1'b0;
        #1;
        check("rst_an",      32'(an),      32'd0);
        check("rst_bcd",     32'(bcd),     32'd0);
        check("rst_dig_idx", 32'(dig_idx), 32'd0);
        check("rst_frame",   32'(frame),   32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // frame 0: idle zeros; load 1234 for frame 1
        push_frame(4'b1111, 16'h0000, 4);
        push_frame(4'b1111, 16'h1234, 4);
        do_load(10, 16'h1234);
        check("pend_rise", 32'(pending), 32'd1);
        at_neg(62);  check("pend_hold", 32'(pending), 32'd1);
        at_neg(63);  check("pend_fall", 32'(pending), 32'd0);

        // frame 1: two loads, last wins
        push_frame(4'b1111, 16'h5678, 4);
        do_load(74, 16'h1111);
        do_load(84, 16'h5678);
        check("pend_2nd", 32'(pending), 32'd1);
        at_neg(126); check("pend_2hold", 32'(pending), 32'd1);
        at_neg(127); check("pend_2fall", 32'(pending), 32'd0);

        // load on the commit edge
        push_frame(4'b1111, 16'h0042, 4);
        do_load(191, 16'h0042);
        check("pend_bypass", 32'(pending), 32'd0);
        at_neg(192); check("pend_bypass2", 32'(pending), 32'd0);

        // leading-zero blanking
        push_frame(4'b0011, 16'h0042, 4);
        at_neg(255);
        lzb = 1'b1;
        push_frame(4'b0001, 16'h0000, 4);
        do_load(260, 16'h0000);

        // invalid codes, then a value for the reset frame
        push_frame(4'b1010, 16'h9A0F, 4);
        do_load(330, 16'h9A0F);
        push_frame(4'b0111, 16'h0500, 3);
        do_load(400, 16'h0500);
        do_load(453, 16'h7777);
        at_neg(486);
        check("pend_before_rst", 32'(pending), 32'd1);
        check("an_before_rst",   32'(an),      32'b0100);
        @(posedge clk);
        #2;
        rst = 1'b1;
        lzb = 1'b0;
        #1;
        check("async_an",      32'(an),      32'd0);
        check("async_pending", 32'(pending), 32'd0);
        check("async_dig_idx", 32'(dig_idx), 32'd0);
        check("async_bcd",     32'(bcd),     32'd0);
        push_frame(4'b1111, 16'h0000, 4);
        push_frame(4'b1111, 16'h0000, 4);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        at_neg(10);  check("post_rst_pending", 32'(pending), 32'd0);
        at_neg(130);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sevseg_scan_ctrl.md
# sevseg_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display built around one shared `sevseg` BCD decoder. It holds a DIGITS-wide BCD value and walks a one-hot digit enable across the display. For each digit slot it steers the active nibble onto the decoder's `bcd` input. New values are taken through a load port and committed only at frame boundaries, so a frame never mixes old and new digits. The block also provides per-slot anti-ghosting blanking, leading-zero blanking and blanking of invalid codes.

## Interface
- DIGITS, 4, number of digits (1..8); digit 0 is least significant
- DIV, 1000, clock cycles per digit slot (DIV > BLANK, DIV >= 2)
- BLANK, 8, cycles at the start of each slot with all enables off (0 = no blanking)
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- load  in  1  one-cycle strobe; capture `din`
- din  in  4*DIGITS  packed BCD value; digit k = din[4k+3:4k]
- lzb  in  1  leading-zero blanking enable (sampled every cycle)
- bcd  out  4  nibble to the shared `sevseg` decoder
- an  out  DIGITS  one-hot active-high digit enable, or all zero
- dig_idx  out  3  index of the current slot
- frame  out  1  one-cycle pulse on the first cycle of each frame
- pending  out  1  a loaded value is waiting for commit

## Operation
- Registers:
  - `disp` holds the displayed value.
  - `shadow` holds the load buffer.
  - `cnt` counts 0..DIV-1 within a slot.
  - `dig_idx` counts 0..DIGITS-1.
  - `state` is BLANK or ON.
- FSM:
  - BLANK: `an` = 0. Move to ON when `cnt` reaches BLANK-1. When BLANK = 0, BLANK is never entered.
  - ON: `an` = onehot(`dig_idx`) if the digit is visible, else 0. Move to BLANK at `cnt` = DIV-1 (to ON when BLANK = 0).
- At `cnt` = DIV-1: `cnt` goes to 0 and `dig_idx` increments. After DIGITS-1 it wraps to 0, which starts a new frame.
- Load handling:
  - When `load` = 1, `shadow` <= `din` and `pending` <= 1.
  - A further load while `pending` is set overwrites `shadow`; the last value wins.
- Commit happens on the edge that starts a new frame:
  - If `pending`, then `disp` <= `shadow` and `pending` <= 0.
  - If `load` is asserted on that same edge, `din` goes straight into `disp` and `pending` <= 0.
- Visibility: digit k is visible unless either condition holds:
  - its nibble is greater than 9 (invalid code is blanked), or
  - `lzb` = 1, k > 0, and nibbles k..DIGITS-1 of `disp` are all zero.
- Digit 0 is always shown when it is valid, so a value of zero displays as "0".
- `bcd` = `disp` nibble at `dig_idx` during ON, and 0 otherwise.
- All outputs are registered and glitch-free.

## Timing
- Reset values, applied immediately on `rst` rise with no clock required:
  - `an` = 0, `bcd` = 0, `dig_idx` = 0, `frame` = 0, `pending` = 0
  - `disp` = 0, `shadow` = 0, `cnt` = 0
  - `state` = BLANK (ON when BLANK = 0)
- Cycle numbering: t = 0 is the first rising edge after `rst` falls. Slot k of frame f spans t in [(f·DIGITS+k)·DIV, (f·DIGITS+k+1)·DIV).
- Within a slot, outputs after edge t:
  - `an` = 0 for slot offsets 0..BLANK-1.
  - Enable and `bcd` are valid for offsets BLANK..DIV-1.
  - `dig_idx` changes on the slot's first edge.
- Frame period is DIGITS·DIV cycles.
- `frame` = 1 for exactly one cycle at slot-0 offset 0 of every frame after the first. It is not asserted on the first frame after reset.
- Load-to-display latency: the value appears on the next frame edge, at most DIGITS·DIV cycles later.
- `pending` rises on the cycle after `load` and falls on the commit edge.
- `lzb` changes take effect from the next edge.
- `rst` asserted mid-slot or mid-frame: all state clears asynchronously and the scan restarts at digit 0. Any pending load is discarded.

## Test plan
Parameters for all scenarios: DIGITS = 4, DIV = 16, BLANK = 4.
- Reset then idle, `lzb` = 0 -> `an` cycles 0001, 0010, 0100, 1000, each enabled for 12 of 16 cycles with 4 blank cycles first; `bcd` = 0 throughout; `frame` pulses every 64 cycles starting at t = 64.
- Load `din` = 16'h1234 at t = 10 -> `pending` = 1 from t = 11 to t = 64; from t = 64 the slots show 4, 3, 2, 1 on enables 0001..1000.
- Two loads at t = 10 (16'h1111) and t = 20 (16'h5678) -> only 5678 is ever displayed; `pending` is continuous from t = 11 to t = 64.
- Load 16'h0042 at t = 63, coincident with the commit edge -> 0042 is displayed from t = 64 and `pending` stays 0. Then set `lzb` = 1 -> digits 3 and 2 have `an` = 0 and digits 1 and 0 show 4 and 2. Load 16'h0000 -> only digit 0 is enabled, showing 0.
- Load 16'h9A0F -> digits 0 (F) and 2 (A) are never enabled; digit 1 shows 0 and digit 3 shows 9.
- Assert `rst` at slot 2 offset 7 with a load pending -> `an` = 0 and `pending` = 0 immediately without a clock edge; after release the scan restarts at digit 0 with `bcd` = 0.
